// File: rtl/serial_bcd_result_rx_pkg.sv
// Shared types and constants for the serial BCD result receiver:
// FSM state encoding, BCD digit limit and seven-segment glyph table.
package serial_bcd_pkg;

   localparam int RES_BITS_DEF = 20;
   localparam int LOAD_LAT_DEF = 1;

   localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_SHIFT,
      ST_HOLD
   } rx_state_t;

   // Active-high segments {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_LUT [10] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

endpackage

// File: rtl/serial_bcd_result_rx_bcd_to_7seg.sv
// Combinational BCD nibble to seven-segment decoder; non-BCD values show a dash.
module bcd_to_7seg
   import serial_bcd_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      if (nibble <= BCD_DIGIT_MAX) seg = SEG_LUT[nibble];
   end

endmodule

// File: rtl/serial_bcd_result_rx.sv
// Deserialises the ALU's MSB-first BCD result after en falls and offers it on valid/ready.
// Optional SERIAL_BCD_SEG_EN adds a registered seven-segment output per digit.
module serial_bcd_result_rx
   import serial_bcd_pkg::*;
#(
   parameter int RES_BITS = RES_BITS_DEF,
   parameter int LOAD_LAT = LOAD_LAT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                ser_in,
   output logic [RES_BITS-1:0] res_data,
   output logic                res_valid,
   input  logic                res_ready,
   output logic                res_err,
   output logic                busy,
   output logic                overrun
`ifdef SERIAL_BCD_SEG_EN
   ,
   output logic [7*(RES_BITS/4)-1:0] seg
`endif
);

   localparam int CW = $clog2(((RES_BITS > LOAD_LAT) ? RES_BITS : LOAD_LAT) + 1);
   localparam rx_state_t      START_ST  = (LOAD_LAT == 0) ? ST_SHIFT : ST_WAIT;
   localparam logic [CW-1:0]  START_CNT = (LOAD_LAT == 0) ? CW'(RES_BITS) : CW'(LOAD_LAT - 1);

   rx_state_t           state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [RES_BITS-1:0] shreg_q, shreg_d;
   logic [RES_BITS-1:0] data_q, data_d;
   logic                valid_q, valid_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;
   logic                overrun_q, overrun_d;
   logic                en_q;

   logic start, rise, accept, nib_err;

   assign start  = en_q & ~en;
   assign rise   = ~en_q & en;
   assign accept = valid_q & res_ready;

   always_comb begin
      nib_err = 1'b0;
      for (int unsigned i = 0; i < RES_BITS / 4; i++)
         if (shreg_q[4*i +: 4] > BCD_DIGIT_MAX) nib_err = 1'b1;
   end

   // SHIFT counts RES_BITS samples down to zero, then spends one more edge
   // moving the assembled word into res_data.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shreg_d   = shreg_q;
      data_d    = data_q;
      valid_d   = valid_q;
      err_d     = err_q;
      overrun_d = overrun_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = START_ST;
               cnt_d   = START_CNT;
            end
         end
         ST_WAIT: begin
            if (rise) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_d = ST_SHIFT;
               cnt_d   = CW'(RES_BITS);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_SHIFT: begin
            if (rise) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_d = ST_HOLD;
               data_d  = shreg_q;
               valid_d = 1'b1;
               err_d   = nib_err;
            end else begin
               shreg_d = {shreg_q[RES_BITS-2:0], ser_in};
               cnt_d   = cnt_q - CW'(1);
            end
         end
         ST_HOLD: begin
            if (accept) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
               if (start) begin
                  state_d = START_ST;
                  cnt_d   = START_CNT;
               end
            end else if (start) begin
               overrun_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_WAIT) || (state_d == ST_SHIFT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         shreg_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         en_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shreg_q   <= shreg_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
         en_q      <= en;
      end
   end

   assign res_data  = data_q;
   assign res_valid = valid_q;
   assign res_err   = err_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

`ifdef SERIAL_BCD_SEG_EN
   localparam int DIGITS = RES_BITS / 4;

   logic [7*DIGITS-1:0] seg_d, seg_q;

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      bcd_to_7seg u_dec (
         .nibble (data_q[4*g +: 4]),
         .seg    (seg_d[7*g +: 7])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) seg_q <= '0;
      else     seg_q <= seg_d;
   end

   assign seg = seg_q;
`endif

endmodule

// File: tb/tb_serial_bcd_result_rx.sv
// Directed bench for serial_bcd_result_rx: frame table plus abort, reset, overrun
// and accept-with-restart sequences.
module tb_serial_bcd_result_rx;

   logic        clk = 1'b0;
   logic        rst, en, ser_in, res_ready;
   logic [19:0] res_data;
   logic        res_valid, res_err, busy, overrun;
`ifdef SERIAL_BCD_SEG_EN
   logic [34:0] seg;
`endif

   serial_bcd_result_rx #(.RES_BITS(20), .LOAD_LAT(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .ser_in    (ser_in),
      .res_data  (res_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_err   (res_err),
      .busy      (busy),
      .overrun   (overrun)
`ifdef SERIAL_BCD_SEG_EN
      ,
      .seg       (seg)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [19:0] stream;
      logic [19:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs [6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

`ifdef SERIAL_BCD_SEG_EN
   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'd0: return 7'h3F;
         4'd1: return 7'h06;
         4'd2: return 7'h5B;
         4'd3: return 7'h4F;
         4'd4: return 7'h66;
         4'd5: return 7'h6D;
         4'd6: return 7'h7D;
         4'd7: return 7'h07;
         4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   function automatic logic [34:0] exp_seg(input logic [19:0] d);
      logic [34:0] r;
      r = '0;
      for (int k = 0; k < 5; k++) r[7*k +: 7] = seg_of(d[4*k +: 4]);
      return r;
   endfunction
`endif

   // Caller leaves en high for at least one edge first. Edge E0 sees en low;
   // bits are sampled on E2..E21; res_valid must rise on E22.
   task automatic run_frame(input logic [19:0] val, input logic rdy0);
      en        = 1'b0;
      res_ready = rdy0;
      tick();
      res_ready = 1'b0;
      check("busy_after_start", 64'(busy), 64'd1);
      check("valid_after_start", 64'(res_valid), 64'd0);
      tick();
      for (int k = 19; k >= 0; k--) begin
         ser_in = val[k];
         tick();
      end
      ser_in = 1'b0;
      check("valid_edge21", 64'(res_valid), 64'd0);
      tick();
      check("valid_edge22", 64'(res_valid), 64'd1);
      check("busy_in_hold", 64'(busy), 64'd0);
   endtask

   task automatic accept_frame(input logic [19:0] data_now);
      en        = 1'b1;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("valid_after_accept", 64'(res_valid), 64'd0);
`ifdef SERIAL_BCD_SEG_EN
      check("seg", 64'(seg), 64'(exp_seg(data_now)));
`else
      check("data_kept_after_accept", 64'(res_data), 64'(data_now));
`endif
   endtask

   initial begin
      vecs[0] = '{stream: 20'h19998, exp_data: 20'h19998, exp_err: 1'b0};
      vecs[1] = '{stream: 20'h0A123, exp_data: 20'h0A123, exp_err: 1'b1};
      vecs[2] = '{stream: 20'h00042, exp_data: 20'h00042, exp_err: 1'b0};
      vecs[3] = '{stream: 20'h99999, exp_data: 20'h99999, exp_err: 1'b0};
      vecs[4] = '{stream: 20'hF0000, exp_data: 20'hF0000, exp_err: 1'b1};
      vecs[5] = '{stream: 20'h5A5A5, exp_data: 20'h5A5A5, exp_err: 1'b1};

      rst       = 1'b0;
      en        = 1'b0;
      ser_in    = 1'b0;
      res_ready = 1'b0;
      #1 rst = 1'b1;
      #2;
      check("rst_valid", 64'(res_valid), 64'd0);
      check("rst_data", 64'(res_data), 64'd0);
      check("rst_err", 64'(res_err), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_overrun", 64'(overrun), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      en  = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         run_frame(vecs[i].stream, 1'b0);
         check("tbl_data", 64'(res_data), 64'(vecs[i].exp_data));
         check("tbl_err", 64'(res_err), 64'(vecs[i].exp_err));
         accept_frame(vecs[i].exp_data);
      end
      check("no_overrun_yet", 64'(overrun), 64'd0);

      // accept and restart on the same edge
      run_frame(20'h12345, 1'b0);
      check("pre_restart_data", 64'(res_data), 64'h12345);
      en = 1'b1;
      tick();
      run_frame(20'h00907, 1'b1);
      check("restart_data", 64'(res_data), 64'h00907);
      check("restart_no_overrun", 64'(overrun), 64'd0);
      accept_frame(20'h00907);

      // abort after 8 shifted bits
      en = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 8; k++) begin
         ser_in = 1'b1;
         tick();
      end
      en = 1'b1;
      tick();
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_valid", 64'(res_valid), 64'd0);
      for (int k = 0; k < 25; k++) tick();
      check("abort_valid_later", 64'(res_valid), 64'd0);
      run_frame(20'h00042, 1'b0);
      check("post_abort_data", 64'(res_data), 64'h00042);
      check("post_abort_err", 64'(res_err), 64'd0);
      accept_frame(20'h00042);

      // asynchronous reset after 10 shifted bits
      en = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 10; k++) begin
         ser_in = k[0];
         tick();
      end
      rst = 1'b1;
      #1;
      check("midrst_valid", 64'(res_valid), 64'd0);
      check("midrst_data", 64'(res_data), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_err", 64'(res_err), 64'd0);
      #2 rst = 1'b0;
      ser_in = 1'b0;
      en     = 1'b1;
      tick();
      run_frame(20'h31415, 1'b0);
      check("post_rst_data", 64'(res_data), 64'h31415);
      accept_frame(20'h31415);

      // second frame while first still unaccepted
      run_frame(20'h19998, 1'b0);
      check("ovr_first_data", 64'(res_data), 64'h19998);
      en = 1'b1;
      tick();
      en = 1'b0;
      tick();
      check("ovr_flag", 64'(overrun), 64'd1);
      check("ovr_valid_kept", 64'(res_valid), 64'd1);
      check("ovr_data_kept", 64'(res_data), 64'h19998);
      check("ovr_not_busy", 64'(busy), 64'd0);
      for (int k = 0; k < 5; k++) begin
         ser_in = 1'b1;
         tick();
      end
      check("ovr_data_stable", 64'(res_data), 64'h19998);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("ovr_valid_drop", 64'(res_valid), 64'd0);
      check("ovr_sticky", 64'(overrun), 64'd1);
      tick();
      check("ovr_sticky_later", 64'(overrun), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
